top_jpeg_par: RTL and testbench



---
 rtl/top_jpeg_par_pkg.sv | 40 ++++
 rtl/top_jpeg_par_lane.sv | 37 +++
 rtl/top_jpeg_par_ram.sv | 30 +++
 rtl/top_jpeg_par.sv | 114 +++++++++++
 tb/tb_top_jpeg_par.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/top_jpeg_par_pkg.sv
// Shared constants, flag encodings and context bundle for the parallel
// JPEG-2000 5/3 lifting engine.
package top_jpeg_par_pkg;

    localparam int LANES = 16;
    localparam int SW    = 9;
    localparam int FW    = 5;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int WW    = LANES * SW;
    localparam int FLW   = LANES * FW;

    localparam logic [FW-1:0] F_FPRED = 5'd7;
    localparam logic [FW-1:0] F_FUPD  = 5'd5;
    localparam logic [FW-1:0] F_IPRED = 5'd6;
    localparam logic [FW-1:0] F_IUPD  = 5'd4;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
        logic [8:0] z;
        logic [9:0] x;
        logic [3:0] ma_row;
    } ctx_t;

    // Flag ROM image: the same op on every lane, selected by address
    function automatic logic [FLW-1:0] flag_rom(input logic [AW-1:0] a);
        logic [FW-1:0] f;
        f = '0;
        case (a)
            10'd0:   f = F_FPRED;
            10'd1:   f = F_FUPD;
            10'd2:   f = F_IPRED;
            10'd3:   f = F_IUPD;
            default: f = '0;
        endcase
        return {LANES{f}};
    endfunction

endpackage

// File: rtl/top_jpeg_par_lane.sv
// One combinational 5/3 lifting lane: predict/update in both directions,
// 11-bit signed intermediates, result wrapped to 9 bits.
module lift_lane
    import top_jpeg_par_pkg::*;
(
    input  logic [SW-1:0] l_i,
    input  logic [SW-1:0] s_i,
    input  logic [SW-1:0] r_i,
    input  logic [FW-1:0] f_i,
    output logic [SW-1:0] y_o
);

    logic signed [10:0] sum;
    logic signed [10:0] half;
    logic signed [10:0] quart;
    logic signed [10:0] s11;
    logic signed [10:0] y11;

    always_comb begin
        sum   = $signed({{2{l_i[SW-1]}}, l_i})
              + $signed({{2{r_i[SW-1]}}, r_i});
        half  = sum >>> 1;
        quart = (sum + 11'sd2) >>> 2;
        s11   = $signed({{2{s_i[SW-1]}}, s_i});
        y11   = s11;
        case (f_i)
            F_FPRED: y11 = s11 - half;
            F_FUPD:  y11 = s11 + quart;
            F_IPRED: y11 = s11 + half;
            F_IUPD:  y11 = s11 - quart;
            default: y11 = s11;
        endcase
    end

    assign y_o = y11[SW-1:0];

endmodule

// File: rtl/top_jpeg_par_ram.sv
// Generic single-port RAM, registered read with read-before-write;
// reset clears only the read register.
module sp_ram
    import top_jpeg_par_pkg::*;
#(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) dout_q <= '0;
        else     dout_q <= mem_q[addr_i];
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/top_jpeg_par.sv
// Parallel 16-lane 5/3 lifting engine with operand/result registers,
// local sample/result RAMs and the per-lane flag ROM.
module top_jpeg_par
    import top_jpeg_par_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [WW-1:0]   left_s_i,
    input  logic [WW-1:0]   sam_s_i,
    input  logic [WW-1:0]   right_s_i,
    input  logic [FLW-1:0]  flgs_s_i,
    input  logic            update_s,
    output logic            noupdate_s,
    output logic [WW-1:0]   flat_lf,
    output logic [WW-1:0]   flat_sa,
    output logic [WW-1:0]   flat_rt,
    output logic [9:0]      res_out_x,
    input  logic [9:0]      row_ind,
    input  logic [9:0]      col_ind,
    input  logic [8:0]      z,
    input  logic [9:0]      x,
    input  logic [3:0]      ma_row,
    input  logic [3:0]      ma_col,
    input  logic [9:0]      bits_in_sig,
    output logic [8:0]      vv,
    input  logic [WW-1:0]   din_lf,
    input  logic [WW-1:0]   din_sa,
    input  logic [WW-1:0]   din_rt,
    input  logic [AW-1:0]   addr_lf,
    input  logic [AW-1:0]   addr_sa,
    input  logic [AW-1:0]   addr_rt,
    input  logic            we_lf,
    input  logic            we_sa,
    input  logic            we_rt,
    output logic [WW-1:0]   dout_lf,
    output logic [WW-1:0]   dout_sa,
    output logic [WW-1:0]   dout_rt,
    input  logic [SW-1:0]   din_res,
    input  logic [AW-1:0]   addr_res,
    input  logic            we_res,
    output logic [SW-1:0]   dout_res,
    input  logic [AW-1:0]   addr_flgs,
    output logic [FLW-1:0]  dout_flgs
);

    logic [WW-1:0]  flat_lf_q, flat_sa_q, flat_rt_q;
    logic [WW-1:0]  res_q, res_d;
    logic           noupd_q;
    ctx_t           ctx_q;
    logic [FLW-1:0] flgs_q;
    logic [SW-1:0]  sel;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lift_lane u_lane (
            .l_i (left_s_i[k*SW +: SW]),
            .s_i (sam_s_i[k*SW +: SW]),
            .r_i (right_s_i[k*SW +: SW]),
            .f_i (flgs_s_i[k*FW +: FW]),
            .y_o (res_d[k*SW +: SW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flat_lf_q <= '0;
            flat_sa_q <= '0;
            flat_rt_q <= '0;
            res_q     <= '0;
            ctx_q     <= '0;
            noupd_q   <= 1'b1;
        end else begin
            noupd_q <= ~update_s;
            if (update_s) begin
                flat_lf_q <= left_s_i;
                flat_sa_q <= sam_s_i;
                flat_rt_q <= right_s_i;
                res_q     <= res_d;
                ctx_q     <= '{row_ind, col_ind, z, x, ma_row};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) flgs_q <= '0;
        else     flgs_q <= flag_rom(addr_flgs);
    end

    sp_ram #(.W(WW)) u_lf (
        .clk, .rst, .we_i(we_lf), .addr_i(addr_lf),
        .din_i(din_lf), .dout_o(dout_lf)
    );
    sp_ram #(.W(WW)) u_sa (
        .clk, .rst, .we_i(we_sa), .addr_i(addr_sa),
        .din_i(din_sa), .dout_o(dout_sa)
    );
    sp_ram #(.W(WW)) u_rt (
        .clk, .rst, .we_i(we_rt), .addr_i(addr_rt),
        .din_i(din_rt), .dout_o(dout_rt)
    );
    sp_ram #(.W(SW)) u_res (
        .clk, .rst, .we_i(we_res), .addr_i(addr_res),
        .din_i(din_res), .dout_o(dout_res)
    );

    assign sel        = res_q[ma_col*SW +: SW];
    assign res_out_x  = {sel[SW-1], sel};
    assign noupdate_s = noupd_q;
    assign flat_lf    = flat_lf_q;
    assign flat_sa    = flat_sa_q;
    assign flat_rt    = flat_rt_q;
    assign dout_flgs  = flgs_q;
    assign vv         = bits_in_sig[9:1];

endmodule

// File: tb/tb_top_jpeg_par.sv
// Randomized bench for top_jpeg_par against a lane-arithmetic and
// array-memory reference model, plus directed literal checks.
module tb_top_jpeg_par;

    logic clk = 0;
    logic rst;
    logic [143:0] left_s_i, sam_s_i, right_s_i;
    logic [79:0]  flgs_s_i;
    logic update_s;
    logic noupdate_s;
    logic [143:0] flat_lf, flat_sa, flat_rt;
    logic [9:0] res_out_x;
    logic [9:0] row_ind, col_ind, x;
    logic [8:0] z;
    logic [3:0] ma_row, ma_col;
    logic [9:0] bits_in_sig;
    logic [8:0] vv;
    logic [143:0] din_lf, din_sa, din_rt, dout_lf, dout_sa, dout_rt;
    logic [9:0] addr_lf, addr_sa, addr_rt;
    logic we_lf, we_sa, we_rt;
    logic [8:0] din_res, dout_res;
    logic [9:0] addr_res;
    logic we_res;
    logic [9:0] addr_flgs;
    logic [79:0] dout_flgs;

    top_jpeg_par dut (
        .clk(clk), .rst(rst),
        .left_s_i(left_s_i), .sam_s_i(sam_s_i), .right_s_i(right_s_i),
        .flgs_s_i(flgs_s_i), .update_s(update_s), .noupdate_s(noupdate_s),
        .flat_lf(flat_lf), .flat_sa(flat_sa), .flat_rt(flat_rt),
        .res_out_x(res_out_x),
        .row_ind(row_ind), .col_ind(col_ind), .z(z), .x(x),
        .ma_row(ma_row), .ma_col(ma_col),
        .bits_in_sig(bits_in_sig), .vv(vv),
        .din_lf(din_lf), .din_sa(din_sa), .din_rt(din_rt),
        .addr_lf(addr_lf), .addr_sa(addr_sa), .addr_rt(addr_rt),
        .we_lf(we_lf), .we_sa(we_sa), .we_rt(we_rt),
        .dout_lf(dout_lf), .dout_sa(dout_sa), .dout_rt(dout_rt),
        .din_res(din_res), .addr_res(addr_res), .we_res(we_res),
        .dout_res(dout_res),
        .addr_flgs(addr_flgs), .dout_flgs(dout_flgs)
    );

    always #5 clk = ~clk;

    localparam logic [143:0] P_LF = 144'h5229138a452291389c4e271389c5227148a4;
    localparam logic [143:0] P_SA = 144'h0123456789abcdef0fedcba9876543210aa5;
    localparam logic [143:0] P_RT = 144'hdeadbeefcafef00d123456789abcdef05a5a;

    int passed = 0;
    int total  = 0;
    bit chk_en = 0;

    task automatic chk(input string n, input logic [143:0] a, input logic [143:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
        else passed++;
    endtask

    // Reference lane arithmetic in plain integers
    function automatic logic [8:0] lift(input logic [8:0] l9, input logic [8:0] s9,
                                        input logic [8:0] r9, input logic [4:0] f);
        int l, s, r, v;
        l = $signed(l9); s = $signed(s9); r = $signed(r9);
        case (f)
            5'd7:    v = s - ((l + r) >>> 1);
            5'd5:    v = s + ((l + r + 2) >>> 2);
            5'd6:    v = s + ((l + r) >>> 1);
            5'd4:    v = s - ((l + r + 2) >>> 2);
            default: v = s;
        endcase
        return v[8:0];
    endfunction

    function automatic logic [79:0] rom(input logic [9:0] a);
        logic [4:0] f;
        f = (a == 0) ? 5'd7 : (a == 1) ? 5'd5 : (a == 2) ? 5'd6 : (a == 3) ? 5'd4 : 5'd0;
        return {16{f}};
    endfunction

    // Model state
    logic [143:0] m_lf [1024], m_sa [1024], m_rt [1024];
    logic [8:0]   m_res [1024];
    bit v_lf [1024], v_sa [1024], v_rt [1024], v_res [1024];
    logic [143:0] e_flat_lf, e_flat_sa, e_flat_rt;
    logic [8:0]   e_res [16];
    bit           e_noupd;
    logic [143:0] e_dlf, e_dsa, e_drt;
    logic [8:0]   e_dres;
    logic [79:0]  e_dflg;
    bit dv_lf, dv_sa, dv_rt, dv_res;

    always @(posedge clk) begin
        if (rst) begin
            e_flat_lf = '0; e_flat_sa = '0; e_flat_rt = '0;
            for (int k = 0; k < 16; k++) e_res[k] = '0;
            e_noupd = 1;
            e_dlf = '0; e_dsa = '0; e_drt = '0; e_dres = '0; e_dflg = '0;
            dv_lf = 1; dv_sa = 1; dv_rt = 1; dv_res = 1;
        end else begin
            e_noupd = !update_s;
            if (update_s) begin
                e_flat_lf = left_s_i; e_flat_sa = sam_s_i; e_flat_rt = right_s_i;
                for (int k = 0; k < 16; k++)
                    e_res[k] = lift(left_s_i[9*k +: 9], sam_s_i[9*k +: 9],
                                    right_s_i[9*k +: 9], flgs_s_i[5*k +: 5]);
            end
            e_dlf = m_lf[addr_lf];   dv_lf  = v_lf[addr_lf];
            e_dsa = m_sa[addr_sa];   dv_sa  = v_sa[addr_sa];
            e_drt = m_rt[addr_rt];   dv_rt  = v_rt[addr_rt];
            e_dres = m_res[addr_res]; dv_res = v_res[addr_res];
            e_dflg = rom(addr_flgs);
        end
        if (we_lf)  begin m_lf[addr_lf] = din_lf;    v_lf[addr_lf] = 1; end
        if (we_sa)  begin m_sa[addr_sa] = din_sa;    v_sa[addr_sa] = 1; end
        if (we_rt)  begin m_rt[addr_rt] = din_rt;    v_rt[addr_rt] = 1; end
        if (we_res) begin m_res[addr_res] = din_res; v_res[addr_res] = 1; end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [8:0] e;
            e = e_res[ma_col];
            chk("flat_lf", flat_lf, e_flat_lf);
            chk("flat_sa", flat_sa, e_flat_sa);
            chk("flat_rt", flat_rt, e_flat_rt);
            chk("res_out_x", res_out_x, {e[8], e});
            chk("noupdate_s", noupdate_s, e_noupd);
            chk("vv", vv, bits_in_sig[9:1]);
            chk("dout_flgs", dout_flgs, e_dflg);
            if (dv_lf)  chk("dout_lf", dout_lf, e_dlf);
            if (dv_sa)  chk("dout_sa", dout_sa, e_dsa);
            if (dv_rt)  chk("dout_rt", dout_rt, e_drt);
            if (dv_res) chk("dout_res", dout_res, e_dres);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [9:0] a, input logic [8:0] l, input logic [8:0] s,
                         input logic [8:0] r, input logic [8:0] exp, input string n);
        addr_flgs = a;
        tick();
        flgs_s_i  = dout_flgs;
        left_s_i  = {135'b0, l};
        sam_s_i   = {135'b0, s};
        right_s_i = {135'b0, r};
        ma_col    = 0;
        update_s  = 1;
        tick();
        update_s  = 0;
        chk({n, "_res"}, res_out_x, {exp[8], exp});
        chk({n, "_noupd0"}, noupdate_s, 1'b0);
        tick();
        chk({n, "_noupd1"}, noupdate_s, 1'b1);
    endtask

    initial begin
        rst = 1; update_s = 0;
        left_s_i = '0; sam_s_i = '0; right_s_i = '0; flgs_s_i = '0;
        row_ind = 0; col_ind = 0; z = 0; x = 0; ma_row = 0; ma_col = 0;
        bits_in_sig = 0;
        din_lf = '0; din_sa = '0; din_rt = '0;
        addr_lf = 0; addr_sa = 0; addr_rt = 0;
        we_lf = 0; we_sa = 0; we_rt = 0;
        din_res = 0; addr_res = 0; we_res = 0; addr_flgs = 0;
        tick(); tick();
        rst = 0;
        tick();
        chk_en = 1;
        chk("rst_noupd", noupdate_s, 1'b1);
        chk("rst_res", res_out_x, 10'h000);
        chk("rst_flat", flat_sa, 144'h0);

        din_lf = P_LF; din_sa = P_SA; din_rt = P_RT;
        we_lf = 1; we_sa = 1; we_rt = 1;
        tick();
        we_lf = 0; we_sa = 0; we_rt = 0;
        tick();
        chk("ram_lf", dout_lf, P_LF);
        chk("ram_sa", dout_sa, P_SA);
        chk("ram_rt", dout_rt, P_RT);

        bits_in_sig = 10'h3ff;
        #1;
        chk("vv_3ff", vv, 9'h1ff);
        din_res = vv; addr_res = 0; we_res = 1;
        tick();
        bits_in_sig = 10'h3fe;
        #1;
        din_res = vv; addr_res = 1;
        tick();
        we_res = 0; addr_res = 0;
        tick();
        chk("res_rd0", dout_res, 9'h1ff);
        addr_res = 1;
        tick();
        chk("res_rd1", dout_res, 9'h1ff);

        do_op(10'd0, 9'd4, 9'd10, 9'd6, 9'd5,  "fpred");
        do_op(10'd1, 9'd4, 9'd10, 9'd6, 9'd13, "fupd");
        do_op(10'd3, 9'd4, 9'd10, 9'd6, 9'd7,  "iupd");
        do_op(10'd2, 9'd4, 9'd10, 9'd6, 9'd15, "ipred");
        do_op(10'd2, 9'h100, 9'h0ff, 9'h100, 9'h1ff, "wrap");
        chk("wrap_ext", res_out_x, 10'h3ff);

        for (int i = 0; i < 400; i++) begin
            logic [79:0] f;
            for (int k = 0; k < 16; k++) f[5*k +: 5] = 5'($urandom_range(0, 8));
            flgs_s_i  = f;
            left_s_i  = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            sam_s_i   = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            right_s_i = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            update_s  = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 40) == 0);
            ma_col    = 4'($urandom);
            row_ind = 10'($urandom); col_ind = 10'($urandom);
            z = 9'($urandom); x = 10'($urandom); ma_row = 4'($urandom);
            bits_in_sig = 10'($urandom);
            din_lf = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            din_sa = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            din_rt = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            din_res = 9'($urandom);
            addr_lf = 10'(16 + $urandom_range(0, 7));
            addr_sa = 10'(16 + $urandom_range(0, 7));
            addr_rt = 10'(16 + $urandom_range(0, 7));
            addr_res = 10'(16 + $urandom_range(0, 7));
            addr_flgs = 10'($urandom_range(0, 5));
            we_lf  = !rst && $urandom_range(0, 1);
            we_sa  = !rst && $urandom_range(0, 1);
            we_rt  = !rst && $urandom_range(0, 1);
            we_res = !rst && $urandom_range(0, 1);
            tick();
        end

        we_lf = 0; we_sa = 0; we_rt = 0; we_res = 0;
        addr_lf = 0; ma_col = 0;
        left_s_i = P_LF; sam_s_i = P_SA; right_s_i = P_RT;
        update_s = 1; rst = 1;
        tick();
        rst = 0; update_s = 0;
        chk("rstupd_noupd", noupdate_s, 1'b1);
        chk("rstupd_res", res_out_x, 10'h000);
        chk("rstupd_flat", flat_lf, 144'h0);
        chk("rstupd_dout", dout_lf, 144'h0);
        tick();
        chk("ram_keep", dout_lf, P_LF);
        tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
